// File: rtl/row_accumulator.sv
// Sums the signed products of one sparse row and queues {row_sum, row_index} in a show-ahead FIFO.
// Optional macro ROW_ACC_SAT_EN: sticky saturating accumulation instead of two's-complement wrap.
module row_accumulator #(
    parameter int PROD_W     = 64,
    parameter int ACC_W      = 72,
    parameter int NNZ_W      = 11,
    parameter int ROW_W      = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclr,
    input  logic              row_len_valid,
    input  logic [NNZ_W-1:0]  row_len,
    output logic              row_len_ready,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              res_valid,
    output logic [ACC_W-1:0]  res_data,
    output logic [ROW_W-1:0]  res_row,
    input  logic              res_ready,
    output logic              busy,
    output logic              err_orphan
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t                  state_q, state_d;
    logic [NNZ_W-1:0]        len_q, len_d;
    logic [NNZ_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic                    err_q, err_d;
    logic [PTR_W-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]          fcnt_q, fcnt_d;
    logic                    push, pop, full;
    logic signed [ACC_W-1:0] prod_ext;

    logic signed [ACC_W-1:0] mem_data [FIFO_DEPTH];
    logic [ROW_W-1:0]        mem_row  [FIFO_DEPTH];

`ifdef ROW_ACC_SAT_EN
    logic sat_q, sat_d;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    function automatic logic add_ovf(input logic signed [ACC_W-1:0] a,
                                     input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W-1:0] s;
        s = a + b;
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        if (add_ovf(a, b))
            return a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        return a + b;
    endfunction
`else
    function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                         input logic signed [ACC_W-1:0] b);
        return a + b;
    endfunction
`endif

    assign prod_ext      = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign row_len_ready = (state_q == IDLE);
    assign prod_ready    = (state_q == ACCUM);
    assign res_valid     = (fcnt_q != '0);
    assign full          = (fcnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign pop           = res_valid && res_ready;
    // Memory is not reset; the head is masked so an empty FIFO reads as zero.
    assign res_data      = res_valid ? mem_data[rd_q] : '0;
    assign res_row       = res_valid ? mem_row[rd_q]  : '0;
    assign busy          = (state_q != IDLE) || res_valid;
    assign err_orphan    = err_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        row_d   = row_q;
        err_d   = err_q | (prod_valid && !prod_ready);
        wr_d    = wr_q;
        rd_d    = rd_q;
        fcnt_d  = fcnt_q;
        push    = 1'b0;
`ifdef ROW_ACC_SAT_EN
        sat_d   = sat_q;
`endif

        case (state_q)
            IDLE: begin
                if (row_len_valid) begin
                    len_d   = row_len;
                    cnt_d   = '0;
                    sum_d   = '0;
`ifdef ROW_ACC_SAT_EN
                    sat_d   = 1'b0;
`endif
                    state_d = (row_len == '0) ? FLUSH : ACCUM;
                end
            end
            ACCUM: begin
                if (prod_valid) begin
`ifdef ROW_ACC_SAT_EN
                    // Once clipped, the sum is pinned until the row completes.
                    if (!sat_q) begin
                        sum_d = sat_add(sum_q, prod_ext);
                        sat_d = add_ovf(sum_q, prod_ext);
                    end
`else
                    sum_d = wrap_add(sum_q, prod_ext);
`endif
                    cnt_d = cnt_q + NNZ_W'(1);
                    if (cnt_q + NNZ_W'(1) == len_q)
                        state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (!full || pop) begin
                    push    = 1'b1;
                    row_d   = row_q + ROW_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push)
            wr_d = wr_q + PTR_W'(1);
        if (pop)
            rd_d = rd_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   fcnt_d = fcnt_q + (PTR_W+1)'(1);
            2'b01:   fcnt_d = fcnt_q - (PTR_W+1)'(1);
            default: fcnt_d = fcnt_q;
        endcase

        if (sclr) begin
            state_d = IDLE;
            len_d   = '0;
            cnt_d   = '0;
            sum_d   = '0;
            row_d   = '0;
            err_d   = 1'b0;
            wr_d    = '0;
            rd_d    = '0;
            fcnt_d  = '0;
            push    = 1'b0;
`ifdef ROW_ACC_SAT_EN
            sat_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            fcnt_q  <= '0;
`ifdef ROW_ACC_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            row_q   <= row_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            fcnt_q  <= fcnt_d;
`ifdef ROW_ACC_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    // FIFO storage: a push in FLUSH writes the finished sum with its row index.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_q] <= sum_q;
            mem_row[wr_q]  <= row_q;
        end
    end

endmodule

// File: tb/tb_row_accumulator.sv
// Directed bench for row_accumulator: row sums, zero-length rows, FIFO back-pressure, row wrap, overflow, orphan and reset.
module tb_row_accumulator;

    localparam int PROD_W     = 64;
    localparam int ACC_W      = 72;
    localparam int NNZ_W      = 11;
    localparam int ROW_W      = 8;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              sclr;
    logic              row_len_valid;
    logic [NNZ_W-1:0]  row_len;
    logic              row_len_ready;
    logic              prod_valid;
    logic [PROD_W-1:0] prod;
    logic              prod_ready;
    logic              res_valid;
    logic [ACC_W-1:0]  res_data;
    logic [ROW_W-1:0]  res_row;
    logic              res_ready;
    logic              busy;
    logic              err_orphan;

    int checks   = 0;
    int failures = 0;

    row_accumulator #(
        .PROD_W(PROD_W), .ACC_W(ACC_W), .NNZ_W(NNZ_W), .ROW_W(ROW_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .sclr(sclr),
        .row_len_valid(row_len_valid), .row_len(row_len), .row_len_ready(row_len_ready),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
        .res_valid(res_valid), .res_data(res_data), .res_row(res_row), .res_ready(res_ready),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_len(input logic [NNZ_W-1:0] l);
        int n = 0;
        while (!row_len_ready && n < 100) begin tick(); n++; end
        chk("row_len_ready_wait", row_len_ready, 1);
        row_len_valid = 1'b1;
        row_len       = l;
        tick();
        row_len_valid = 1'b0;
    endtask

    task automatic send_prod(input logic [PROD_W-1:0] p);
        int n = 0;
        while (!prod_ready && n < 100) begin tick(); n++; end
        chk("prod_ready_wait", prod_ready, 1);
        prod_valid = 1'b1;
        prod       = p;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [ACC_W-1:0] exp_data, input logic [ROW_W-1:0] exp_row);
        int n = 0;
        while (!res_valid && n < 100) begin tick(); n++; end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_data"}, res_data, exp_data);
        chk({tag, "_row"}, res_row, exp_row);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        logic [ROW_W-1:0]        nrow;
        logic signed [PROD_W-1:0] v;
        logic [ACC_W-1:0]        e;

        reset = 1'b0; sclr = 1'b0; row_len_valid = 1'b0; row_len = '0;
        prod_valid = 1'b0; prod = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row_len_ready", row_len_ready, 1);
        chk("rst_prod_ready", prod_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_row", res_row, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_orphan, 0);
        reset = 1'b1;
        tick();

        // Row 0: 5, -2, 7 -> 10, result visible one edge after the last product
        send_len(3);
        send_prod(64'd5);
        send_prod(-64'sd2);
        send_prod(64'd7);
        chk("t1_flush_res_valid", res_valid, 0);
        chk("t1_flush_busy", busy, 1);
        chk("t1_flush_len_ready", row_len_ready, 0);
        tick();
        chk("t1_push_res_valid", res_valid, 1);
        pop("t1", 72'd10, 8'd0);

        // Synchronous clear restarts row numbering
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("sclr_busy", busy, 0);

        send_len(0);
        chk("t2_zero_flush_valid", res_valid, 0);
        tick();
        chk("t2_zero_push_valid", res_valid, 1);
        pop("t2_zero", 72'd0, 8'd0);
        send_len(1);
        send_prod(-64'sd1);
        pop("t2_neg", {ACC_W{1'b1}}, 8'd1);
        nrow = 8'd2;

        // Back-pressure: five rows with the consumer stalled
        for (int i = 0; i < 5; i++) begin
            send_len(1);
            send_prod(64'(100 + i));
        end
        tick();
        tick();
        chk("t3_stall_len_ready", row_len_ready, 0);
        chk("t3_stall_prod_ready", prod_ready, 0);
        chk("t3_stall_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            pop("t3_drain", 72'(100 + i), nrow + ROW_W'(i));
            if (i == 0) chk("t3_release_len_ready", row_len_ready, 1);
        end
        chk("t3_empty", res_valid, 0);
        nrow = nrow + 8'd5;

        // 300 single-product rows: row index wraps through 255 -> 0
        for (int i = 0; i < 300; i++) begin
            v = 64'(i) * 64'sd1000 - 64'sd150000;
            send_len(1);
            send_prod(v);
            pop("t4", {{(ACC_W-PROD_W){v[PROD_W-1]}}, v}, nrow);
            nrow = nrow + 8'd1;
        end

        // 300 x (2^63-1) overflows 72 bits
        send_len(300);
        for (int i = 0; i < 300; i++)
            send_prod(64'h7FFF_FFFF_FFFF_FFFF);
`ifdef ROW_ACC_SAT_EN
        e = {1'b0, {(ACC_W-1){1'b1}}};
`else
        e = 72'd300 * 72'h7FFF_FFFF_FFFF_FFFF;
`endif
        pop("t5_big", e, nrow);
        nrow = nrow + 8'd1;

        // Orphan product in IDLE: flag is sticky and the product is dropped
        prod_valid = 1'b1;
        prod       = 64'd123;
        tick();
        prod_valid = 1'b0;
        chk("t6_err_set", err_orphan, 1);
        tick();
        tick();
        chk("t6_err_sticky", err_orphan, 1);
        send_len(1);
        send_prod(64'd6);
        pop("t6_after_orphan", 72'd6, nrow);
        chk("t6_err_still", err_orphan, 1);

        // Asynchronous reset in the middle of a row
        send_len(3);
        send_prod(64'd50);
        send_prod(64'd60);
        reset = 1'b0;
        #1;
        chk("t7_rst_len_ready", row_len_ready, 1);
        chk("t7_rst_prod_ready", prod_ready, 0);
        chk("t7_rst_res_valid", res_valid, 0);
        chk("t7_rst_res_data", res_data, 0);
        chk("t7_rst_res_row", res_row, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_err", err_orphan, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        send_len(2);
        send_prod(64'd4);
        send_prod(64'd5);
        pop("t7_fresh", 72'd9, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
